// File: rtl/lc3_int_ctrl_if.sv
// Bus between the LC-3 control unit and the interrupt controller.
// The control unit side is master; the controller is slave.
interface lc3_int_ctrl_if #(
   parameter int NUM_SRC = 8
) ();
   logic [NUM_SRC-1:0] irqReq;
   logic [2:0]         curPriority;
   logic               cfgWE;
   logic [3:0]         cfgSel;
   logic [2:0]         cfgPri;
   logic               cfgEn;
   logic               cfgEdge;
   logic               intAck;
   logic               eoi;
   logic               INT;
   logic [7:0]         INTV;
   logic [2:0]         intPri;
   logic [NUM_SRC-1:0] inService;

   modport master (
      output irqReq, curPriority, cfgWE, cfgSel, cfgPri,
      output cfgEn, cfgEdge, intAck, eoi,
      input  INT, INTV, intPri, inService
   );

   modport slave (
      input  irqReq, curPriority, cfgWE, cfgSel, cfgPri,
      input  cfgEn, cfgEdge, intAck, eoi,
      output INT, INTV, intPri, inService
   );
endinterface

// File: rtl/lc3_int_ctrl.sv
// Prioritised interrupt controller for the LC-3: per-source config,
// edge/level pending, in-service tracking and a 3-state request FSM.
module lc3_int_ctrl #(
   parameter int         NUM_SRC  = 8,
   parameter logic [7:0] VEC_BASE = 8'h80
) (
   input logic           clk,
   input logic           rst,
   lc3_int_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

   state_t state;

   logic [2:0]         pri [NUM_SRC];
   logic [NUM_SRC-1:0] en;
   logic [NUM_SRC-1:0] edgeMode;
   logic [NUM_SRC-1:0] pendReg;
   logic [NUM_SRC-1:0] prevIrq;
   logic [NUM_SRC-1:0] inSvc;

   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] ackMask;
   logic [NUM_SRC-1:0] eoiMask;

   logic [3:0] winIdx;
   logic [2:0] winPri;
   logic       intR;
   logic [7:0] vecR;
   logic [2:0] priR;

   logic       arbFound;
   logic [3:0] arbIdx;
   logic [2:0] arbPri;
   logic       eoiFound;
   logic [3:0] eoiIdx;
   logic [2:0] eoiPri;
   logic       winElig;
   logic       ackNow;

   assign bus.INT       = intR;
   assign bus.INTV      = vecR;
   assign bus.intPri    = priR;
   assign bus.inService = inSvc;

   assign pending = (edgeMode & pendReg) | (~edgeMode & bus.irqReq);
   assign ackNow  = (state == ASSERT) && bus.intAck;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_SRC; i++)
         elig[i] = pending[i] && en[i] && !inSvc[i] &&
                   (pri[i] > bus.curPriority);
   end

   // Strict '>' keeps the lowest index on priority ties.
   always_comb begin
      arbFound = 1'b0;
      arbIdx   = '0;
      arbPri   = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (elig[i] && (!arbFound || pri[i] > arbPri)) begin
            arbFound = 1'b1;
            arbIdx   = 4'(i);
            arbPri   = pri[i];
         end
   end

   always_comb begin
      eoiFound = 1'b0;
      eoiIdx   = '0;
      eoiPri   = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (inSvc[i] && (!eoiFound || pri[i] > eoiPri)) begin
            eoiFound = 1'b1;
            eoiIdx   = 4'(i);
            eoiPri   = pri[i];
         end
   end

   always_comb begin
      winElig = 1'b0;
      ackMask = '0;
      eoiMask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (winIdx == 4'(i))
            winElig = elig[i];
         ackMask[i] = ackNow && (winIdx == 4'(i));
         eoiMask[i] = bus.eoi && eoiFound && (eoiIdx == 4'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         winIdx   <= '0;
         winPri   <= '0;
         intR     <= 1'b0;
         vecR     <= VEC_BASE;
         priR     <= '0;
         en       <= '0;
         edgeMode <= '0;
         pendReg  <= '0;
         prevIrq  <= '0;
         inSvc    <= '0;
         for (int i = 0; i < NUM_SRC; i++)
            pri[i] <= '0;
      end else begin
         prevIrq <= bus.irqReq;
         pendReg <= edgeMode &
                    ((pendReg & ~ackMask) | (bus.irqReq & ~prevIrq));
         // eoi target comes from the pre-acknowledge in-service set.
         inSvc   <= (inSvc & ~eoiMask) | ackMask;

         for (int i = 0; i < NUM_SRC; i++)
            if (bus.cfgWE && bus.cfgSel == 4'(i)) begin
               pri[i]      <= bus.cfgPri;
               en[i]       <= bus.cfgEn;
               edgeMode[i] <= bus.cfgEdge;
            end

         case (state)
            IDLE: begin
               if (arbFound) begin
                  state  <= ASSERT;
                  winIdx <= arbIdx;
                  winPri <= arbPri;
                  intR   <= 1'b1;
                  vecR   <= VEC_BASE + {4'b0000, arbIdx};
                  priR   <= arbPri;
               end
            end
            ASSERT: begin
               if (bus.intAck) begin
                  state <= HOLD;
                  intR  <= 1'b0;
               end else if (!winElig) begin
                  state <= IDLE;
                  intR  <= 1'b0;
               end
            end
            HOLD: begin
               state <= IDLE;
               intR  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               intR  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Scoreboard bench for lc3_int_ctrl: expectations are queued with the
// stimulus and drained one clock later against the DUT outputs.
module tb_lc3_int_ctrl;
   logic clk = 1'b0;
   logic rst;

   lc3_int_ctrl_if #(.NUM_SRC(8)) bus ();

   lc3_int_ctrl #(.NUM_SRC(8), .VEC_BASE(8'h80)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      int         w;
      logic [7:0] v;
   } exp_t;

   exp_t sb[$];
   int   nChk  = 0;
   int   nPass = 0;

   localparam int W_INT = 0;
   localparam int W_VEC = 1;
   localparam int W_PRI = 2;
   localparam int W_SVC = 3;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] want);
      nChk++;
      if (got === want)
         nPass++;
      else
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
   endtask

   function automatic logic [7:0] obs(input int w);
      case (w)
         W_INT:   return {7'b0, bus.INT};
         W_VEC:   return bus.INTV;
         W_PRI:   return {5'b0, bus.intPri};
         default: return bus.inService;
      endcase
   endfunction

   task automatic want(input string tag, input int w, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.w   = w;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic wantReq(input string tag, input logic [7:0] vec,
                          input logic [7:0] p);
      want({tag, ".int"}, W_INT, 8'h01);
      want({tag, ".vec"}, W_VEC, vec);
      want({tag, ".pri"}, W_PRI, p);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, obs(e.w), e.v);
      end
   endtask

   task automatic cfg(input logic [3:0] s, input logic [2:0] p,
                      input logic e, input logic ed);
      bus.cfgWE   = 1'b1;
      bus.cfgSel  = s;
      bus.cfgPri  = p;
      bus.cfgEn   = e;
      bus.cfgEdge = ed;
      tick();
      bus.cfgWE   = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      bus.irqReq      = '0;
      bus.curPriority = '0;
      bus.cfgWE       = 1'b0;
      bus.cfgSel      = '0;
      bus.cfgPri      = '0;
      bus.cfgEn       = 1'b0;
      bus.cfgEdge     = 1'b0;
      bus.intAck      = 1'b0;
      bus.eoi         = 1'b0;
      tick();
      want("rst.int", W_INT, 8'h00);
      want("rst.vec", W_VEC, 8'h80);
      want("rst.pri", W_PRI, 8'h00);
      want("rst.svc", W_SVC, 8'h00);
      tick();
      rst = 1'b0;

      // Basic level request, ack, HOLD, ignored ack, eoi
      bus.curPriority = 3'd2;
      cfg(4'd2, 3'd4, 1'b1, 1'b0);
      bus.irqReq = 8'h04;
      wantReq("lvl", 8'h82, 8'h04);
      tick();
      bus.intAck = 1'b1;
      want("lvl.ackInt", W_INT, 8'h00);
      want("lvl.ackSvc", W_SVC, 8'h04);
      tick();
      bus.intAck = 1'b0;
      bus.irqReq = '0;
      want("lvl.hold", W_INT, 8'h00);
      tick();
      bus.intAck = 1'b1;
      want("idleAck", W_SVC, 8'h04);
      tick();
      bus.intAck = 1'b0;
      bus.eoi    = 1'b1;
      want("lvl.eoi", W_SVC, 8'h00);
      tick();
      bus.eoi = 1'b0;

      // Tie, higher priority, no pre-emption
      cfg(4'd1, 3'd5, 1'b1, 1'b0);
      cfg(4'd6, 3'd5, 1'b1, 1'b0);
      bus.irqReq = 8'h42;
      wantReq("tie", 8'h81, 8'h05);
      tick();
      bus.irqReq = '0;
      want("tie.drop", W_INT, 8'h00);
      tick();
      cfg(4'd6, 3'd6, 1'b1, 1'b0);
      bus.irqReq = 8'h42;
      wantReq("hiPri", 8'h86, 8'h06);
      tick();
      bus.irqReq = '0;
      want("hiPri.drop", W_INT, 8'h00);
      tick();
      bus.irqReq = 8'h02;
      want("latch1", W_VEC, 8'h81);
      tick();
      bus.irqReq = 8'h42;
      wantReq("noPreempt", 8'h81, 8'h05);
      tick();
      bus.intAck = 1'b1;
      want("ack1.int", W_INT, 8'h00);
      want("ack1.svc", W_SVC, 8'h02);
      tick();
      bus.intAck = 1'b0;
      want("hold1", W_INT, 8'h00);
      tick();
      wantReq("next6", 8'h86, 8'h06);
      tick();
      bus.intAck = 1'b1;
      want("ack6.svc", W_SVC, 8'h42);
      tick();
      bus.intAck = 1'b0;
      bus.irqReq = '0;
      want("hold6", W_INT, 8'h00);
      tick();
      bus.eoi = 1'b1;
      want("eoiHi", W_SVC, 8'h02);
      tick();
      want("eoiLo", W_SVC, 8'h00);
      tick();
      bus.eoi = 1'b0;

      // In-service pair, repeated eoi, eoi with ack
      bus.curPriority = 3'd0;
      cfg(4'd0, 3'd2, 1'b1, 1'b0);
      cfg(4'd2, 3'd7, 1'b1, 1'b0);
      for (int r = 0; r < 2; r++) begin
         bus.irqReq = 8'h05;
         wantReq("pair.src2", 8'h82, 8'h07);
         tick();
         bus.intAck = 1'b1;
         want("pair.ack2", W_SVC, 8'h04);
         tick();
         bus.intAck = 1'b0;
         want("pair.hold", W_INT, 8'h00);
         tick();
         wantReq("pair.src0", 8'h80, 8'h02);
         tick();
         bus.intAck = 1'b1;
         bus.eoi    = (r == 1);
         want("pair.ack0", W_SVC, (r == 1) ? 8'h01 : 8'h05);
         tick();
         bus.intAck = 1'b0;
         bus.eoi    = 1'b0;
         bus.irqReq = '0;
         want("pair.hold0", W_INT, 8'h00);
         tick();
         if (r == 0) begin
            bus.eoi = 1'b1;
            want("eoi1", W_SVC, 8'h01);
            tick();
            want("eoi2", W_SVC, 8'h00);
            tick();
            want("eoi3", W_SVC, 8'h00);
            tick();
            bus.eoi = 1'b0;
         end else begin
            bus.eoi = 1'b1;
            want("eoiAck.clr", W_SVC, 8'h00);
            tick();
            bus.eoi = 1'b0;
         end
      end

      // Edge-mode source with a one-cycle pulse
      cfg(4'd3, 3'd3, 1'b1, 1'b1);
      bus.irqReq = 8'h08;
      want("edge.n1", W_INT, 8'h00);
      tick();
      bus.irqReq = '0;
      wantReq("edge.n2", 8'h83, 8'h03);
      tick();
      want("edge.held", W_INT, 8'h01);
      tick();
      bus.intAck = 1'b1;
      want("edge.ack", W_INT, 8'h00);
      want("edge.svc", W_SVC, 8'h08);
      tick();
      bus.intAck = 1'b0;
      want("edge.hold", W_INT, 8'h00);
      tick();
      bus.eoi = 1'b1;
      want("edge.eoi", W_SVC, 8'h00);
      tick();
      bus.eoi = 1'b0;
      for (int k = 0; k < 2; k++) begin
         want("edge.noRe", W_INT, 8'h00);
         tick();
      end

      // Level request withdrawn before ack
      bus.irqReq = 8'h01;
      wantReq("wd", 8'h80, 8'h02);
      tick();
      bus.irqReq = '0;
      want("wd.int", W_INT, 8'h00);
      want("wd.svc", W_SVC, 8'h00);
      tick();
      want("wd.idle", W_INT, 8'h00);
      tick();

      // Config write disables the latched winner
      bus.irqReq = 8'h01;
      want("cfgW.req", W_INT, 8'h01);
      tick();
      want("cfgW.same", W_INT, 8'h01);
      cfg(4'd0, 3'd2, 1'b0, 1'b0);
      want("cfgW.wd", W_INT, 8'h00);
      tick();
      cfg(4'd0, 3'd2, 1'b1, 1'b0);
      want("relatch", W_INT, 8'h01);
      tick();

      // Reset during ASSERT with concurrent write and ack
      rst         = 1'b1;
      bus.cfgWE   = 1'b1;
      bus.cfgSel  = 4'd0;
      bus.cfgPri  = 3'd7;
      bus.cfgEn   = 1'b1;
      bus.intAck  = 1'b1;
      want("mrst.int", W_INT, 8'h00);
      want("mrst.vec", W_VEC, 8'h80);
      want("mrst.pri", W_PRI, 8'h00);
      want("mrst.svc", W_SVC, 8'h00);
      tick();
      rst        = 1'b0;
      bus.cfgWE  = 1'b0;
      bus.intAck = 1'b0;
      want("mrst.noWr", W_INT, 8'h00);
      tick();

      // Out-of-range selector must not alias onto a real source
      bus.irqReq = 8'h10;
      cfg(4'd12, 3'd7, 1'b1, 1'b0);
      want("oor.ign", W_INT, 8'h00);
      tick();
      cfg(4'd4, 3'd7, 1'b1, 1'b0);
      wantReq("src4", 8'h84, 8'h07);
      tick();

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end
endmodule
